// File: rtl/fft4_pkg.sv
// fft4_pkg: complex word type, FSM states and pack/unpack/narrow helpers for fft4.
// Parts are held sign-extended to CW bits, so butterfly growth never wraps internally.
// Define FFT4_SCALE_EN to scale results by 1/4 (floor); otherwise results wrap to H bits.
package fft4_pkg;

    // Widest supported part; WIDTH/2 + 2 must fit, so WIDTH <= 60.
    localparam int CW = 32;

    typedef struct packed {
        logic signed [CW-1:0] re;
        logic signed [CW-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ST1  = 2'd1,
        ST2  = 2'd2,
        DONE = 2'd3
    } state_t;

    // w carries a packed word {re[h-1:0], im[h-1:0]} in its low 2h bits.
    function automatic cplx_t cplx_unpack(input logic [2*CW-1:0] w, input int h);
        cplx_t                  c;
        logic signed [2*CW-1:0] t;
        t    = $signed(w << (2*CW - 2*h));
        c.re = CW'(t >>> (2*CW - h));
        t    = $signed(w << (2*CW - h));
        c.im = CW'(t >>> (2*CW - h));
        return c;
    endfunction

    // Keeps only the low h bits of each part, which is where wrap-around happens.
    function automatic logic [2*CW-1:0] cplx_pack(input cplx_t c, input int h);
        logic [2*CW-1:0] m;
        m = ((2*CW)'(1) << h) - (2*CW)'(1);
        return ((((2*CW)'($signed(c.re))) & m) << h) | (((2*CW)'($signed(c.im))) & m);
    endfunction

    function automatic cplx_t cplx_narrow(input cplx_t c);
        cplx_t r;
`ifdef FFT4_SCALE_EN
        r.re = $signed(c.re) >>> 2;
        r.im = $signed(c.im) >>> 2;
`else
        r = c;
`endif
        return r;
    endfunction

endpackage

// File: rtl/fft4_bfly.sv
// fft4_bfly: complex radix-2 butterfly, sum = a + b and dif = a - b per part.
// Latency: combinational. Backpressure: none.
module fft4_bfly #(
    parameter int W = 32
) (
    input  logic signed [W-1:0] a_re,
    input  logic signed [W-1:0] a_im,
    input  logic signed [W-1:0] b_re,
    input  logic signed [W-1:0] b_im,
    output logic signed [W-1:0] sum_re,
    output logic signed [W-1:0] sum_im,
    output logic signed [W-1:0] dif_re,
    output logic signed [W-1:0] dif_im
);

    // The caller sizes W with headroom for the one bit of growth.
    assign sum_re = a_re + b_re;
    assign sum_im = a_im + b_im;
    assign dif_re = a_re - b_re;
    assign dif_im = a_im - b_im;

endmodule

// File: rtl/fft4.sv
// fft4: 4-point complex DFT, two registered radix-2 stages; FFT4_SCALE_EN selects /4 output scaling.
// Latency: 3 cycles start->done, one transform per 4 cycles.
// Backpressure: none; start is ignored outside IDLE, done is a one-cycle pulse.
module fft4
    import fft4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             done,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3
);

    localparam int HW = WIDTH / 2;

    state_t state;
    cplx_t  x0, x1, x2, x3;
    cplx_t  a, b, c, d;
    cplx_t  sa, sb, sc, sd;
    cplx_t  y0, y1, y2, y3;
    cplx_t  dj;

    // -j*D, so that B + (-jD) is X1 and B - (-jD) is X3.
    assign dj.re = d.im;
    assign dj.im = -$signed(d.re);

    fft4_bfly #(.W(CW)) u_bfly_s1_02 (
        .a_re(x0.re), .a_im(x0.im), .b_re(x2.re), .b_im(x2.im),
        .sum_re(sa.re), .sum_im(sa.im), .dif_re(sb.re), .dif_im(sb.im)
    );

    fft4_bfly #(.W(CW)) u_bfly_s1_13 (
        .a_re(x1.re), .a_im(x1.im), .b_re(x3.re), .b_im(x3.im),
        .sum_re(sc.re), .sum_im(sc.im), .dif_re(sd.re), .dif_im(sd.im)
    );

    fft4_bfly #(.W(CW)) u_bfly_s2_ac (
        .a_re(a.re), .a_im(a.im), .b_re(c.re), .b_im(c.im),
        .sum_re(y0.re), .sum_im(y0.im), .dif_re(y2.re), .dif_im(y2.im)
    );

    fft4_bfly #(.W(CW)) u_bfly_s2_bd (
        .a_re(b.re), .a_im(b.im), .b_re(dj.re), .b_im(dj.im),
        .sum_re(y1.re), .sum_im(y1.im), .dif_re(y3.re), .dif_im(y3.im)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            done  <= 1'b0;
            x0    <= '0;
            x1    <= '0;
            x2    <= '0;
            x3    <= '0;
            a     <= '0;
            b     <= '0;
            c     <= '0;
            d     <= '0;
            out0  <= '0;
            out1  <= '0;
            out2  <= '0;
            out3  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x0    <= cplx_unpack((2*CW)'(in0), HW);
                        x1    <= cplx_unpack((2*CW)'(in1), HW);
                        x2    <= cplx_unpack((2*CW)'(in2), HW);
                        x3    <= cplx_unpack((2*CW)'(in3), HW);
                        state <= ST1;
                    end
                end
                ST1: begin
                    a     <= sa;
                    b     <= sb;
                    c     <= sc;
                    d     <= sd;
                    state <= ST2;
                end
                ST2: begin
                    out0  <= WIDTH'(cplx_pack(cplx_narrow(y0), HW));
                    out1  <= WIDTH'(cplx_pack(cplx_narrow(y1), HW));
                    out2  <= WIDTH'(cplx_pack(cplx_narrow(y2), HW));
                    out3  <= WIDTH'(cplx_pack(cplx_narrow(y3), HW));
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft4.sv
// tb_fft4: table vectors, random vectors against a direct-DFT model, and multi-cycle corner sequences.
module tb_fft4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        done;
    logic [31:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic [31:0] out0, out1, out2, out3;

    int checks = 0;
    int failures = 0;

    fft4 #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] x[4];
        logic [31:0] e[4];
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // X[k] = sum_n x[n] * (-j)^(k*n), then scaled (floor /4) or wrapped to 16 bits per part.
    function automatic logic [31:0] model_bin(input logic [31:0] x[4], input int k);
        logic signed [31:0] sr, si, re, im;
        sr = 0;
        si = 0;
        for (int n = 0; n < 4; n++) begin
            re = 32'($signed(x[n][31:16]));
            im = 32'($signed(x[n][15:0]));
            case ((k * n) % 4)
                0: begin sr = sr + re; si = si + im; end
                1: begin sr = sr + im; si = si - re; end
                2: begin sr = sr - re; si = si - im; end
                default: begin sr = sr - im; si = si + re; end
            endcase
        end
`ifdef FFT4_SCALE_EN
        sr = sr >>> 2;
        si = si >>> 2;
`endif
        return {sr[15:0], si[15:0]};
    endfunction

    task automatic drive(input logic [31:0] v[4]);
        in0 = v[0];
        in1 = v[1];
        in2 = v[2];
        in3 = v[3];
    endtask

    // Issues one start pulse; lat is the negedge count after the capturing edge at which done was seen (0 = never).
    task automatic xform(input logic [31:0] v[4], output logic [31:0] r[4], output int lat);
        @(negedge clk);
        drive(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in0 = $urandom;
        in1 = $urandom;
        in2 = $urandom;
        in3 = $urandom;
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            if (done) lat = i;
            else @(negedge clk);
        end
        r = '{out0, out1, out2, out3};
    endtask

    function automatic logic [15:0] rnd_part();
        case ($urandom_range(0, 3))
            0: return 16'h8000;
            1: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    vec_t        tv[4];
    logic [31:0] v[4], v2[4], r[4];
    int          lat, ndone;
    int          didx[3];

    initial begin
        tv[0].name = "impulse";
        tv[0].x    = '{32'h0004_0000, 32'h0, 32'h0, 32'h0};
        tv[1].name = "constant";
        tv[1].x    = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        tv[2].name = "delayed_impulse";
        tv[2].x    = '{32'h0, 32'h0001_0000, 32'h0, 32'h0};
        tv[3].name = "wrap";
        tv[3].x    = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000};
`ifdef FFT4_SCALE_EN
        tv[0].e = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        tv[1].e = '{32'h0001_0000, 32'h0, 32'h0, 32'h0};
        tv[2].e = '{32'h0000_0000, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_0000};
        tv[3].e = '{32'h7FFF_0000, 32'h0, 32'h0, 32'h0};
`else
        tv[0].e = '{32'h0004_0000, 32'h0004_0000, 32'h0004_0000, 32'h0004_0000};
        tv[1].e = '{32'h0004_0000, 32'h0, 32'h0, 32'h0};
        tv[2].e = '{32'h0001_0000, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_0001};
        tv[3].e = '{32'hFFFC_0000, 32'h0, 32'h0, 32'h0};
`endif

        // Reset state
        @(negedge clk);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_out0", out0, 32'h0);
        chk("reset_out1", out1, 32'h0);
        chk("reset_out2", out2, 32'h0);
        chk("reset_out3", out3, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Table vectors
        foreach (tv[t]) begin
            xform(tv[t].x, r, lat);
            chk({tv[t].name, "_latency"}, 32'(lat), 32'd3);
            for (int k = 0; k < 4; k++)
                chk($sformatf("%s_out%0d", tv[t].name, k), r[k], tv[t].e[k]);
            @(negedge clk);
            chk({tv[t].name, "_done_pulse"}, {31'b0, done}, 32'h0);
            chk({tv[t].name, "_hold_out0"}, out0, tv[t].e[0]);
        end

        // Random vectors against the model
        for (int t = 0; t < 24; t++) begin
            for (int n = 0; n < 4; n++) v[n] = {rnd_part(), rnd_part()};
            xform(v, r, lat);
            chk("rand_latency", 32'(lat), 32'd3);
            for (int k = 0; k < 4; k++)
                chk($sformatf("rand%0d_out%0d", t, k), r[k], model_bin(v, k));
        end

        // Start while busy is ignored
        for (int n = 0; n < 4; n++) begin
            v[n]  = $urandom;
            v2[n] = $urandom;
        end
        @(negedge clk);
        drive(v);
        start = 1'b1;
        @(negedge clk);
        drive(v2);
        @(negedge clk);
        start = 1'b0;
        ndone = done ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                r = '{out0, out1, out2, out3};
            end
        end
        chk("busy_done_count", 32'(ndone), 32'd1);
        for (int k = 0; k < 4; k++)
            chk($sformatf("busy_out%0d", k), r[k], model_bin(v, k));

        // start held high: back-to-back transforms
        for (int n = 0; n < 4; n++) v[n] = $urandom;
        @(negedge clk);
        drive(v);
        start = 1'b1;
        ndone = 0;
        didx  = '{0, 0, 0};
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                if (ndone < 3) didx[ndone] = i;
                ndone++;
            end
        end
        start = 1'b0;
        chk("b2b_done_count", 32'(ndone), 32'd3);
        chk("b2b_first_done", 32'(didx[0]), 32'd3);
        chk("b2b_second_done", 32'(didx[1]), 32'd7);
        chk("b2b_third_done", 32'(didx[2]), 32'd11);
        chk("b2b_out1", out1, model_bin(v, 1));
        repeat (3) @(negedge clk);

        // Reset while in ST2 aborts the transform
        @(negedge clk);
        drive(tv[0].x);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_done", {31'b0, done}, 32'h0);
        chk("rst_mid_out0", out0, 32'h0);
        chk("rst_mid_out1", out1, 32'h0);
        chk("rst_mid_out2", out2, 32'h0);
        chk("rst_mid_out3", out3, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst_abort_no_done", 32'(ndone), 32'd0);
        xform(tv[0].x, r, lat);
        chk("rst_recover_latency", 32'(lat), 32'd3);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rst_recover_out%0d", k), r[k], tv[0].e[k]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
